mem_stage_nb: RTL and testbench
===============================

Name: mem_stage_nb

Overview:
- Non-blocking successor of the single-slot memory stage. It sits between execute and writeback.
- Holds up to DEPTH in-flight instructions in an age-ordered queue, so several loads can await data-sram data_ok at once.
- Responses return in order and are matched to queued loads. Loads are sign/zero-extended, and results retire in program order to writeback.
- On pipeline flush, responses still owed to killed loads are counted and silently discarded.

Parameters:
DEPTH, 2, queue entries; power of two, >=2
CNT_W, $clog2(DEPTH+1), width of occupancy/discard counters (derived, do not override)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
es_to_ms_valid  in  1  execute offers instruction
ms_allowin  out  1  stage accepts this cycle
es_pc  in  32  instruction PC
es_result  in  32  ALU/CSR result
es_dest  in  5  destination GR
es_gr_we  in  1  GR write enable
es_res_from_mem  in  1  result comes from memory
es_load_op  in  5  one-hot {lhu,lbu,lw,lh,lb}
es_mem_req  in  1  request issued to data-sram (load or store)
es_ex  in  1  exception already flagged
es_vaddr_lo  in  2  vaddr[1:0]
data_sram_data_ok  in  1  one in-order response
data_sram_rdata  in  32  response data
ms_flush_pipe  in  1  kill all stage contents
ms_to_ws_valid  out  1  head entry complete
ws_allowin  in  1  writeback accepts
ms_pc  out  32  head PC
ms_final_result  out  32  head result
ms_dest  out  5  head dest
ms_gr_we  out  1  head GR write enable
ms_ex  out  1  head exception
ms_to_es_ex  out  1  any valid entry has ex
ms_fwd_bus  out  DEPTH*39  per age slot i (0 = oldest) {gr_we&valid, done, dest[5], result[32]}
ms_count  out  CNT_W  occupied entries
ms_rsp_err  out  1  sticky: unexpected data_ok

Behaviour:
- Reset (async, reset==0): count=0, discard_cnt=0, ms_rsp_err=0, all entries invalid, all outputs 0. ms_allowin rises the first cycle after deassertion.
- Enqueue:
  - Fires when es_to_ms_valid && ms_allowin.
  - ms_allowin = !ms_flush_pipe && (count + discard_cnt < DEPTH). This bounds total outstanding responses to DEPTH.
  - An entry is done at enqueue if !es_mem_req || es_ex. Otherwise it is pending.
- Response matching:
  - On data_ok with discard_cnt>0: discard_cnt decrements and data is dropped.
  - Else: the oldest pending entry captures extended data and becomes done.
  - Data_ok with no pending entry and discard_cnt==0: ignored, ms_rsp_err<=1 (cleared only by reset).
- Extension:
  - lb/lbu select byte vaddr_lo.
  - lh/lhu select half vaddr_lo[1]. No alignment check here.
  - lw passes the word through.
  - final = res_from_mem ? extended : es_result.
  - A store completes done with es_result.
- Dequeue:
  - ms_to_ws_valid = count>0 && head.done && !ms_flush_pipe.
  - Pops on ms_to_ws_valid && ws_allowin.
  - Head outputs are driven combinationally from head entry, 0 when empty.
- Same-cycle events:
  - Enqueue, capture and dequeue may all occur in one cycle.
  - count += enq - deq.
  - A response may complete the head in the same cycle it arrives; ms_to_ws_valid asserts the next cycle (1-cycle capture latency).
- Flush:
  - All entries are invalidated next cycle and count=0.
  - discard_cnt_next = discard_cnt - (data_ok && discard_cnt>0) + number of entries still pending after this cycle's capture. A data_ok in the flush cycle is consumed first.
- Pointer wrap: head/tail are log2(DEPTH) bits and wrap modulo DEPTH. Full means count==DEPTH.
- ms_to_es_ex = OR over valid entries of ex, gated by !ms_flush_pipe.

Test Plan:
- Reset 0 mid-stream with 2 loads pending -> count=0, ms_to_ws_valid=0, discard_cnt=0 immediately. Later data_ok -> ms_rsp_err=1.
- Two back-to-back loads (lb vaddr_lo=3, lhu vaddr_lo=2), data_ok rdata=0x80FF1234 then 0x80FF1234 with ws_allowin=1 -> results 0xFFFFFF80 then 0x000080FF, in order, PCs preserved.
- DEPTH=2, ws_allowin=0, three offers -> ms_allowin=0 after 2 accepted, count=2. Release ws_allowin -> third accepted the cycle after first pop.
- Flush with 2 pending loads, then enqueue new lw, then 3 data_ok (0x1,0x2,0x3) -> first two dropped, new lw result 0x3, discard_cnt returns to 0.
- Flush coinciding with data_ok, 2 pending -> discard_cnt=1 next cycle. ms_allowin=0 during flush cycle.
- Store with es_ex=1 enqueued, no data_ok -> ms_to_ws_valid next cycle, ms_ex=1, ms_to_es_ex=1 while queued.

Source files
------------

// File: rtl/mem_stage_nb.sv
// mem_stage_nb: non-blocking memory stage with an age-ordered queue of in-flight
// instructions, in-order data_ok matching, load extension and flush discard tracking.
module mem_stage_nb #(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                es_to_ms_valid,
    output logic                ms_allowin,
    input  logic [31:0]         es_pc,
    input  logic [31:0]         es_result,
    input  logic [4:0]          es_dest,
    input  logic                es_gr_we,
    input  logic                es_res_from_mem,
    input  logic [4:0]          es_load_op,
    input  logic                es_mem_req,
    input  logic                es_ex,
    input  logic [1:0]          es_vaddr_lo,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                ms_flush_pipe,
    output logic                ms_to_ws_valid,
    input  logic                ws_allowin,
    output logic [31:0]         ms_pc,
    output logic [31:0]         ms_final_result,
    output logic [4:0]          ms_dest,
    output logic                ms_gr_we,
    output logic                ms_ex,
    output logic                ms_to_es_ex,
    output logic [DEPTH*39-1:0] ms_fwd_bus,
    output logic [CNT_W-1:0]    ms_count,
    output logic                ms_rsp_err
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] r_valid, r_done, r_gr_we, r_ex, r_res_mem;
    logic [31:0]      r_pc     [DEPTH];
    logic [31:0]      r_result [DEPTH];
    logic [4:0]       r_dest   [DEPTH];
    logic [4:0]       r_op     [DEPTH];
    logic [1:0]       r_vlo    [DEPTH];
    logic [PW-1:0]    r_head, r_tail;
    logic [CNT_W-1:0] r_count, r_disc;
    logic             r_rdy, r_rsp_err;

    logic             w_enq, w_deq, w_drop, w_cap, w_err, w_pfound, w_hv;
    logic [PW-1:0]    w_pidx;
    logic [CNT_W-1:0] w_pcnt;
    logic [31:0]      w_ext;

    function automatic logic [31:0] f_ext(input logic [31:0] d, input logic [4:0] op,
                                          input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = lo[1] ? (lo[0] ? d[31:24] : d[23:16]) : (lo[0] ? d[15:8] : d[7:0]);
        h = lo[1] ? d[31:16] : d[15:0];
        return op[0] ? {{24{b[7]}}, b} :
               op[1] ? {{16{h[15]}}, h} :
               op[3] ? {24'b0, b} :
               op[4] ? {16'b0, h} : d;
    endfunction

    // Oldest pending entry in age order, plus how many entries are still pending.
    always_comb begin
        w_pfound = 1'b0;
        w_pidx   = '0;
        w_pcnt   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[r_head + PW'(k)] && !r_done[r_head + PW'(k)]) begin
                if (!w_pfound) begin
                    w_pfound = 1'b1;
                    w_pidx   = r_head + PW'(k);
                end
                w_pcnt = w_pcnt + CNT_W'(1);
            end
        end
    end

    assign w_hv            = r_count != '0;
    assign ms_allowin      = r_rdy && !ms_flush_pipe &&
                             (({1'b0, r_count} + {1'b0, r_disc}) < (CNT_W + 1)'(DEPTH));
    assign w_enq           = es_to_ms_valid && ms_allowin;
    assign ms_to_ws_valid  = w_hv && r_done[r_head] && !ms_flush_pipe;
    assign w_deq           = ms_to_ws_valid && ws_allowin;
    assign w_drop          = data_sram_data_ok && r_disc != '0;
    assign w_cap           = data_sram_data_ok && !w_drop && w_pfound;
    assign w_err           = data_sram_data_ok && !w_drop && !w_pfound;
    assign w_ext           = f_ext(data_sram_rdata, r_op[w_pidx], r_vlo[w_pidx]);

    assign ms_pc           = w_hv ? r_pc[r_head] : '0;
    assign ms_final_result = w_hv ? r_result[r_head] : '0;
    assign ms_dest         = w_hv ? r_dest[r_head] : '0;
    assign ms_gr_we        = w_hv && r_gr_we[r_head];
    assign ms_ex           = w_hv && r_ex[r_head];
    assign ms_to_es_ex     = !ms_flush_pipe && |(r_valid & r_ex);
    assign ms_count        = r_count;
    assign ms_rsp_err      = r_rsp_err;

    for (genvar i = 0; i < DEPTH; i++) begin : g_fwd
        logic [PW-1:0] w_s;
        assign w_s = r_head + PW'(i);
        assign ms_fwd_bus[i*39 +: 39] = {r_gr_we[w_s] & r_valid[w_s], r_done[w_s],
                                         r_dest[w_s], r_result[w_s]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= '0;
            r_done    <= '0;
            r_gr_we   <= '0;
            r_ex      <= '0;
            r_res_mem <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_pc[k]     <= '0;
                r_result[k] <= '0;
                r_dest[k]   <= '0;
                r_op[k]     <= '0;
                r_vlo[k]    <= '0;
            end
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_disc    <= '0;
            r_rdy     <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_err)
                r_rsp_err <= 1'b1;
            if (ms_flush_pipe) begin
                // Responses still owed to killed loads must be swallowed later.
                r_valid <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_disc  <= r_disc - CNT_W'(w_drop) + w_pcnt - CNT_W'(w_cap);
            end else begin
                if (w_enq) begin
                    r_valid[r_tail]   <= 1'b1;
                    r_done[r_tail]    <= !es_mem_req || es_ex;
                    r_gr_we[r_tail]   <= es_gr_we;
                    r_ex[r_tail]      <= es_ex;
                    r_res_mem[r_tail] <= es_res_from_mem;
                    r_pc[r_tail]      <= es_pc;
                    r_result[r_tail]  <= es_result;
                    r_dest[r_tail]    <= es_dest;
                    r_op[r_tail]      <= es_load_op;
                    r_vlo[r_tail]     <= es_vaddr_lo;
                    r_tail            <= r_tail + PW'(1);
                end
                if (w_cap) begin
                    r_done[w_pidx] <= 1'b1;
                    if (r_res_mem[w_pidx])
                        r_result[w_pidx] <= w_ext;
                end
                if (w_deq) begin
                    r_valid[r_head] <= 1'b0;
                    r_head          <= r_head + PW'(1);
                end
                r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
                r_disc  <= r_disc - CNT_W'(w_drop);
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_nb.sv
// tb_mem_stage_nb: directed bench for mem_stage_nb (DEPTH=2) with hand-computed expectations.
module tb_mem_stage_nb;
    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid, ms_allowin;
    logic [31:0] es_pc, es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we, es_res_from_mem;
    logic [4:0]  es_load_op;
    logic        es_mem_req, es_ex;
    logic [1:0]  es_vaddr_lo;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_flush_pipe, ms_to_ws_valid, ws_allowin;
    logic [31:0] ms_pc, ms_final_result;
    logic [4:0]  ms_dest;
    logic        ms_gr_we, ms_ex, ms_to_es_ex;
    logic [77:0] ms_fwd_bus;
    logic [1:0]  ms_count;
    logic        ms_rsp_err;
    int          checks = 0;
    int          errors = 0;

    localparam logic [4:0] LB = 5'b00001, LW = 5'b00100, LHU = 5'b10000;

    mem_stage_nb #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_result(es_result), .es_dest(es_dest), .es_gr_we(es_gr_we),
        .es_res_from_mem(es_res_from_mem), .es_load_op(es_load_op), .es_mem_req(es_mem_req),
        .es_ex(es_ex), .es_vaddr_lo(es_vaddr_lo), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ms_flush_pipe(ms_flush_pipe),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin), .ms_pc(ms_pc),
        .ms_final_result(ms_final_result), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
        .ms_ex(ms_ex), .ms_to_es_ex(ms_to_es_ex), .ms_fwd_bus(ms_fwd_bus),
        .ms_count(ms_count), .ms_rsp_err(ms_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                         input logic gr_we, input logic from_mem, input logic [4:0] op,
                         input logic req, input logic ex, input logic [1:0] lo);
        es_to_ms_valid = 1'b1;
        es_pc = pc; es_result = res; es_dest = dest; es_gr_we = gr_we;
        es_res_from_mem = from_mem; es_load_op = op; es_mem_req = req; es_ex = ex;
        es_vaddr_lo = lo;
    endtask

    task automatic rsp(input logic ok, input logic [31:0] d);
        data_sram_data_ok = ok;
        data_sram_rdata = d;
    endtask

    initial begin
        reset = 1'b0;
        es_to_ms_valid = 0; es_pc = 0; es_result = 0; es_dest = 0; es_gr_we = 0;
        es_res_from_mem = 0; es_load_op = 0; es_mem_req = 0; es_ex = 0; es_vaddr_lo = 0;
        data_sram_data_ok = 0; data_sram_rdata = 0; ms_flush_pipe = 0; ws_allowin = 0;
        tick(); tick();
        chk("rst_allowin", ms_allowin, 0);
        chk("rst_count", ms_count, 0);
        chk("rst_valid", ms_to_ws_valid, 0);
        chk("rst_err", ms_rsp_err, 0);
        reset = 1'b1;
        #1 chk("allowin_before_edge", ms_allowin, 0);
        tick();
        chk("allowin_after_rst", ms_allowin, 1);

        // lb vaddr_lo=3 then lhu vaddr_lo=2
        offer(32'h100, 32'hAAAA, 5'd3, 1, 1, LB, 1, 0, 2'd3);
        tick();
        offer(32'h104, 32'hBBBB, 5'd4, 1, 1, LHU, 1, 0, 2'd2);
        tick();
        es_to_ms_valid = 0;
        ws_allowin = 1;
        #1;
        chk("ld_count2", ms_count, 2);
        chk("ld_allowin_full", ms_allowin, 0);
        chk("ld_not_ready", ms_to_ws_valid, 0);
        rsp(1, 32'h80FF1234);
        tick();
        chk("ld1_valid", ms_to_ws_valid, 1);
        chk("ld1_result", ms_final_result, 32'hFFFFFF80);
        chk("ld1_pc", ms_pc, 32'h100);
        chk("ld1_dest", ms_dest, 3);
        chk("ld1_fwd0", ms_fwd_bus[38:0], {1'b1, 1'b1, 5'd3, 32'hFFFFFF80});
        tick();
        rsp(0, 0);
        #1;
        chk("ld2_valid", ms_to_ws_valid, 1);
        chk("ld2_result", ms_final_result, 32'h000080FF);
        chk("ld2_pc", ms_pc, 32'h104);
        chk("ld2_count", ms_count, 1);
        tick();
        chk("ld_drained", ms_count, 0);
        chk("ld_drained_valid", ms_to_ws_valid, 0);

        // backpressure with three ALU offers
        ws_allowin = 0;
        offer(32'h200, 32'h11, 5'd1, 1, 0, 0, 0, 0, 0);
        tick();
        offer(32'h204, 32'h22, 5'd2, 1, 0, 0, 0, 0, 0);
        #1 chk("bp_allowin1", ms_allowin, 1);
        tick();
        offer(32'h208, 32'h33, 5'd5, 1, 0, 0, 0, 0, 0);
        #1;
        chk("bp_allowin_full", ms_allowin, 0);
        chk("bp_count2", ms_count, 2);
        tick();
        chk("bp_hold_count", ms_count, 2);
        ws_allowin = 1;
        #1;
        chk("bp_head_a", ms_pc, 32'h200);
        chk("bp_allowin_at_pop", ms_allowin, 0);
        tick();
        chk("bp_allowin_after_pop", ms_allowin, 1);
        chk("bp_head_b", ms_pc, 32'h204);
        tick();
        es_to_ms_valid = 0;
        #1;
        chk("bp_head_c", ms_pc, 32'h208);
        chk("bp_result_c", ms_final_result, 32'h33);
        chk("bp_count1", ms_count, 1);
        tick();
        chk("bp_drained", ms_count, 0);
        ws_allowin = 0;

        // flush with two pending loads, then new lw
        offer(32'h300, 0, 5'd6, 1, 1, LW, 1, 0, 0);
        tick();
        offer(32'h304, 0, 5'd7, 1, 1, LW, 1, 0, 0);
        tick();
        es_to_ms_valid = 0;
        ms_flush_pipe = 1;
        #1;
        chk("fl_allowin", ms_allowin, 0);
        chk("fl_valid", ms_to_ws_valid, 0);
        tick();
        ms_flush_pipe = 0;
        #1;
        chk("fl_count0", ms_count, 0);
        chk("fl_disc2_block", ms_allowin, 0);
        rsp(1, 32'h1);
        tick();
        chk("fl_disc1_open", ms_allowin, 1);
        offer(32'h308, 0, 5'd8, 1, 1, LW, 1, 0, 0);
        rsp(1, 32'h2);
        tick();
        es_to_ms_valid = 0;
        rsp(1, 32'h3);
        #1 chk("fl_new_pending", ms_to_ws_valid, 0);
        tick();
        rsp(0, 0);
        #1;
        chk("fl_new_valid", ms_to_ws_valid, 1);
        chk("fl_new_result", ms_final_result, 32'h3);
        chk("fl_new_pc", ms_pc, 32'h308);
        chk("fl_disc0", ms_allowin, 1);
        chk("fl_no_err", ms_rsp_err, 0);
        ws_allowin = 1;
        tick();
        ws_allowin = 0;

        // flush coinciding with data_ok
        offer(32'h400, 0, 5'd9, 1, 1, LW, 1, 0, 0);
        tick();
        offer(32'h404, 0, 5'd10, 1, 1, LW, 1, 0, 0);
        tick();
        es_to_ms_valid = 0;
        ms_flush_pipe = 1;
        rsp(1, 32'h5);
        #1 chk("flr_allowin", ms_allowin, 0);
        tick();
        ms_flush_pipe = 0;
        rsp(0, 0);
        #1 chk("flr_disc_lt2", ms_allowin, 1);
        offer(32'h408, 0, 5'd11, 1, 1, LW, 1, 0, 0);
        tick();
        es_to_ms_valid = 0;
        #1 chk("flr_disc_eq1", ms_allowin, 0);
        rsp(1, 32'h7);
        tick();
        rsp(1, 32'h9);
        #1;
        chk("flr_dropped", ms_to_ws_valid, 0);
        chk("flr_reopen", ms_allowin, 1);
        tick();
        rsp(0, 0);
        #1;
        chk("flr_result", ms_final_result, 32'h9);
        chk("flr_no_err", ms_rsp_err, 0);
        ws_allowin = 1;
        tick();
        ws_allowin = 0;

        // store with exception
        offer(32'h500, 32'h55, 5'd0, 0, 0, 0, 1, 1, 0);
        tick();
        es_to_ms_valid = 0;
        #1;
        chk("st_valid", ms_to_ws_valid, 1);
        chk("st_ex", ms_ex, 1);
        chk("st_to_es_ex", ms_to_es_ex, 1);
        chk("st_result", ms_final_result, 32'h55);
        ws_allowin = 1;
        tick();
        chk("st_popped_ex", ms_to_es_ex, 0);
        chk("st_popped_count", ms_count, 0);
        ws_allowin = 0;

        // async reset with two pending loads
        offer(32'h600, 0, 5'd12, 1, 1, LW, 1, 0, 0);
        tick();
        offer(32'h604, 0, 5'd13, 1, 1, LW, 1, 0, 0);
        tick();
        es_to_ms_valid = 0;
        #1 chk("mr_pre_count", ms_count, 2);
        reset = 1'b0;
        #1;
        chk("mr_count", ms_count, 0);
        chk("mr_valid", ms_to_ws_valid, 0);
        chk("mr_allowin", ms_allowin, 0);
        reset = 1'b1;
        tick();
        #1 chk("mr_disc0", ms_allowin, 1);
        rsp(1, 32'hDEAD);
        tick();
        rsp(0, 0);
        #1 chk("mr_rsp_err", ms_rsp_err, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
